button_press_classifier: RTL and testbench
==========================================

# button_press_classifier

Classifies the clean level from a button debounce stage into discrete user events: short press, long press and double press. Each event is a one-cycle strobe, and a running event count is provided. The block sits directly downstream of the debounce stage and upstream of the UI and control logic, which should consume only these strobes and never the raw debounced level.

## Interface
Parameters:
- LONG_PRESS_CYCLES, default 25_000_000: consecutive high samples that make a long press (1 s at 25 MHz); must be ≥ 2.
- DOUBLE_GAP_CYCLES, default 6_250_000: maximum low samples between two presses that still form a double press (250 ms); must be ≥ 2.

Ports:
- i_Clk, input, 1: the only clock.
- i_Reset, input, 1: reset, synchronous and active-high.
- i_Debounced, input, 1: debounced button level, already synchronous to i_Clk; 1 = pressed.
- o_Short_Press, output, 1: one-cycle strobe for a single short press.
- o_Long_Press, output, 1: one-cycle strobe for a long press.
- o_Double_Press, output, 1: one-cycle strobe for a double press.
- o_Held, output, 1: level, high while a long press is still held.
- o_Event_Count, output, 8: count of all strobes issued, wraps modulo 256.

## Operation
- The block has one counter, of width $clog2(max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES)) + 1. It clears on every state entry.
- It has one arm flag.
- States and transitions:
  - DISARMED (entered on reset):
    - Waits for i_Debounced = 0.
    - The first low sample sets armed and moves to IDLE.
    - A button held through reset never produces an event.
  - IDLE:
    - i_Debounced = 1 → PRESSED1.
  - PRESSED1:
    - The counter increments on each high sample.
    - Release before LONG_PRESS_CYCLES high samples → WAIT_GAP.
    - LONG_PRESS_CYCLES consecutive high samples, counting the entry sample → strobe o_Long_Press and move to LONG_HELD.
  - LONG_HELD:
    - o_Held = 1.
    - Release → IDLE.
    - No further strobes are issued, however long the button is held.
  - WAIT_GAP:
    - The counter increments on each low sample, counting the entry sample.
    - A high sample before DOUBLE_GAP_CYCLES low samples → PRESSED2.
    - DOUBLE_GAP_CYCLES low samples → strobe o_Short_Press and move to IDLE.
  - PRESSED2:
    - Release → strobe o_Double_Press and move to IDLE.
    - There is no long-press timeout in this state; holding the second press of any length still yields a double press.
- At most one strobe is asserted in any cycle. Strobes are mutually exclusive by construction.
- o_Event_Count increments in the same cycle as any strobe. 255 → 0 wraps silently.
- Reset mid-operation:
  - State → DISARMED.
  - All strobes, o_Held and the counter → 0.
  - o_Event_Count → 0.
  - Any in-flight press is discarded without an event.

## Timing
- All outputs are registered. "Asserted at edge X" means high during the cycle that follows rising edge X.
- Reset values: o_Short_Press = o_Long_Press = o_Double_Press = o_Held = 0; o_Event_Count = 0.
- Press first sampled high at edge P. Held through edge P+L−1, where L = LONG_PRESS_CYCLES:
  - o_Long_Press is asserted at edge P+L−1.
  - o_Held is asserted from edge P+L−1 until the edge at which a low sample is taken.
- Release first sampled low at edge R, with no high sample through edge R+G−1, where G = DOUBLE_GAP_CYCLES:
  - o_Short_Press is asserted at edge R+G−1.
  - The short-press decision latency is therefore G−1 cycles after release.
- Second press sampled high at edge Q with Q ≤ R+G−1, and second release sampled low at edge S:
  - o_Double_Press is asserted at edge S.
  - No o_Short_Press is ever issued for the first press.
- A rising sample exactly at edge R+G−1 counts as the second press, because the high input takes priority over the gap timeout.
- Every strobe lasts exactly 1 cycle.

## Test plan
Use L = 8 and G = 4 for all scenarios.
- Short press:
  - Stimulus: reset, i_Debounced low 3 cycles, high 3 cycles, then low.
  - Required: o_Short_Press asserted exactly once, at edge R+3; no other strobes; o_Event_Count = 1.
- Long press:
  - Stimulus: high for 20 cycles, then low.
  - Required: o_Long_Press at edge P+7; o_Held high from edge P+7 until the release sample, then low; o_Event_Count = 1; no o_Short_Press afterwards.
- Double press at the gap boundary:
  - Stimulus: high 2, low 3, high 2, low.
  - Required: o_Double_Press asserted at the second release edge; no short strobe.
  - Repeat with low 4 between the presses: required o_Short_Press for the first press, then a second o_Short_Press for the second press.
- Held through reset:
  - Stimulus: i_Debounced high during reset and for 30 cycles after reset.
  - Required: no strobes and o_Held = 0 throughout.
  - Then low 1 cycle, followed by a short press: required a normal o_Short_Press.
- Reset mid-press:
  - Stimulus: assert i_Reset in PRESSED1, at 5 high samples.
  - Required: all outputs 0 on the following cycle, o_Event_Count = 0, and no long strobe even if the input stays high.
- Count wrap:
  - Stimulus: 257 short presses.
  - Required: o_Event_Count reads 1.

Source files
------------

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into one-cycle short / long / double press
// strobes, a long-press hold level and a wrapping 8-bit event count.
module button_press_classifier #(
  parameter int LONG_PRESS_CYCLES = 25_000_000,
  parameter int DOUBLE_GAP_CYCLES = 6_250_000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Debounced,
  output logic       o_Short_Press,
  output logic       o_Long_Press,
  output logic       o_Double_Press,
  output logic       o_Held,
  output logic [7:0] o_Event_Count
);
  localparam int MAX_CYC = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                           LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYC) + 1;
  // The entry sample is not stored in the counter, so terminal values are N-2.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 2);

  typedef enum logic [2:0] {
    DISARMED, IDLE, PRESSED1, LONG_HELD, WAIT_GAP, PRESSED2
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          r_short, r_long, r_double, r_held;
  logic [7:0]    r_evt;
  logic          w_short, w_long, w_double;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= DISARMED;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == PRESSED1 || r_state == WAIT_GAP)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == DISARMED && !i_Debounced)
        r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DISARMED:  if (!i_Debounced) w_next = IDLE;
      IDLE:      if (i_Debounced && r_armed) w_next = PRESSED1;
      PRESSED1: begin
        if (!i_Debounced)         w_next = WAIT_GAP;
        else if (r_cnt == LONG_LAST) w_next = LONG_HELD;
      end
      LONG_HELD: if (!i_Debounced) w_next = IDLE;
      // A high sample wins over the gap timeout on the same edge.
      WAIT_GAP: begin
        if (i_Debounced)            w_next = PRESSED2;
        else if (r_cnt == GAP_LAST) w_next = IDLE;
      end
      PRESSED2:  if (!i_Debounced) w_next = IDLE;
      default:   w_next = DISARMED;
    endcase
  end

  always_comb begin
    w_long   = 1'b0;
    w_short  = 1'b0;
    w_double = 1'b0;
    case (r_state)
      PRESSED1: w_long   = i_Debounced && (r_cnt == LONG_LAST);
      WAIT_GAP: w_short  = !i_Debounced && (r_cnt == GAP_LAST);
      PRESSED2: w_double = !i_Debounced;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
      r_evt    <= 8'd0;
    end else begin
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_held   <= (w_next == LONG_HELD);
      if (w_short || w_long || w_double)
        r_evt <= r_evt + 8'd1;
    end
  end

  assign o_Short_Press  = r_short;
  assign o_Long_Press   = r_long;
  assign o_Double_Press = r_double;
  assign o_Held         = r_held;
  assign o_Event_Count  = r_evt;
endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with L=8, G=4.
module tb_button_press_classifier;
  localparam int L = 8;
  localparam int G = 4;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Debounced = 1'b0;
  logic       o_Short_Press, o_Long_Press, o_Double_Press, o_Held;
  logic [7:0] o_Event_Count;

  int total = 0, bad = 0;
  int n_s = 0, n_l = 0, n_d = 0, held_seen = 0, multi = 0;

  always #5 i_Clk = ~i_Clk;

  button_press_classifier #(.LONG_PRESS_CYCLES(L), .DOUBLE_GAP_CYCLES(G)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Debounced(i_Debounced),
    .o_Short_Press(o_Short_Press), .o_Long_Press(o_Long_Press),
    .o_Double_Press(o_Double_Press), .o_Held(o_Held),
    .o_Event_Count(o_Event_Count)
  );

  // Present one sample, take one edge, then look at what that edge produced.
  task automatic cyc(input logic d);
    i_Debounced = d;
    @(posedge i_Clk);
    #1;
    n_s += int'(o_Short_Press);
    n_l += int'(o_Long_Press);
    n_d += int'(o_Double_Press);
    if (o_Held) held_seen++;
    if (int'(o_Short_Press) + int'(o_Long_Press) + int'(o_Double_Press) > 1) multi++;
  endtask

  task automatic clr;
    n_s = 0; n_l = 0; n_d = 0; held_seen = 0;
  endtask

  task automatic test_reset;
    i_Reset = 1'b1;
    cyc(1'b0); cyc(1'b0);
    total++;
    if ({o_Short_Press, o_Long_Press, o_Double_Press, o_Held, o_Event_Count} !== 12'h000) begin
      bad++; $display("FAIL reset_outputs got=%h exp=000",
        {o_Short_Press, o_Long_Press, o_Double_Press, o_Held, o_Event_Count});
    end
    i_Reset = 1'b0;
  endtask

  task automatic test_short;
    clr();
    repeat (3) cyc(1'b0);
    repeat (3) cyc(1'b1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    total++;
    if (o_Short_Press !== 1'b0) begin bad++; $display("FAIL short_early got=%b exp=0", o_Short_Press); end
    cyc(1'b0);
    total++;
    if (o_Short_Press !== 1'b1) begin bad++; $display("FAIL short_at_R+3 got=%b exp=1", o_Short_Press); end
    cyc(1'b0);
    total++;
    if (o_Short_Press !== 1'b0) begin bad++; $display("FAIL short_width got=%b exp=0", o_Short_Press); end
    repeat (3) cyc(1'b0);
    total++;
    if (n_s !== 1 || n_l !== 0 || n_d !== 0) begin
      bad++; $display("FAIL short_counts got s=%0d l=%0d d=%0d exp 1/0/0", n_s, n_l, n_d);
    end
    total++;
    if (o_Event_Count !== 8'd1) begin bad++; $display("FAIL short_evt got=%0d exp=1", o_Event_Count); end
  endtask

  task automatic test_long;
    clr();
    cyc(1'b1);
    repeat (6) cyc(1'b1);
    total++;
    if (o_Long_Press !== 1'b0 || o_Held !== 1'b0) begin
      bad++; $display("FAIL long_early got long=%b held=%b exp 0/0", o_Long_Press, o_Held);
    end
    cyc(1'b1);
    total++;
    if (o_Long_Press !== 1'b1 || o_Held !== 1'b1) begin
      bad++; $display("FAIL long_at_P+7 got long=%b held=%b exp 1/1", o_Long_Press, o_Held);
    end
    cyc(1'b1);
    total++;
    if (o_Long_Press !== 1'b0 || o_Held !== 1'b1) begin
      bad++; $display("FAIL long_P+8 got long=%b held=%b exp 0/1", o_Long_Press, o_Held);
    end
    repeat (11) cyc(1'b1);
    total++;
    if (o_Held !== 1'b1) begin bad++; $display("FAIL long_held_end got=%b exp=1", o_Held); end
    cyc(1'b0);
    total++;
    if (o_Held !== 1'b0) begin bad++; $display("FAIL long_release got=%b exp=0", o_Held); end
    repeat (6) cyc(1'b0);
    total++;
    if (n_l !== 1 || n_s !== 0 || n_d !== 0 || o_Event_Count !== 8'd2) begin
      bad++; $display("FAIL long_counts got l=%0d s=%0d d=%0d evt=%0d exp 1/0/0/2",
                      n_l, n_s, n_d, o_Event_Count);
    end
  endtask

  task automatic test_double_boundary;
    clr();
    repeat (2) cyc(1'b1);
    repeat (3) cyc(1'b0);
    repeat (2) cyc(1'b1);
    cyc(1'b0);
    total++;
    if (o_Double_Press !== 1'b1) begin bad++; $display("FAIL double_at_S got=%b exp=1", o_Double_Press); end
    repeat (5) cyc(1'b0);
    total++;
    if (n_d !== 1 || n_s !== 0 || o_Event_Count !== 8'd3) begin
      bad++; $display("FAIL double_counts got d=%0d s=%0d evt=%0d exp 1/0/3", n_d, n_s, o_Event_Count);
    end
    // One more low sample in the gap: two separate short presses.
    clr();
    repeat (2) cyc(1'b1);
    repeat (3) cyc(1'b0);
    cyc(1'b0);
    total++;
    if (o_Short_Press !== 1'b1) begin bad++; $display("FAIL gap4_first_short got=%b exp=1", o_Short_Press); end
    repeat (2) cyc(1'b1);
    repeat (4) cyc(1'b0);
    total++;
    if (o_Short_Press !== 1'b1) begin bad++; $display("FAIL gap4_second_short got=%b exp=1", o_Short_Press); end
    cyc(1'b0);
    total++;
    if (n_s !== 2 || n_d !== 0 || o_Event_Count !== 8'd5) begin
      bad++; $display("FAIL gap4_counts got s=%0d d=%0d evt=%0d exp 2/0/5", n_s, n_d, o_Event_Count);
    end
  endtask

  task automatic test_held_through_reset;
    i_Reset = 1'b1;
    cyc(1'b1); cyc(1'b1);
    i_Reset = 1'b0;
    clr();
    repeat (30) cyc(1'b1);
    total++;
    if (n_s + n_l + n_d !== 0 || held_seen !== 0 || o_Event_Count !== 8'd0) begin
      bad++; $display("FAIL held_reset_quiet got strobes=%0d held=%0d evt=%0d exp 0/0/0",
                      n_s + n_l + n_d, held_seen, o_Event_Count);
    end
    cyc(1'b0);
    repeat (3) cyc(1'b1);
    repeat (4) cyc(1'b0);
    total++;
    if (o_Short_Press !== 1'b1 || o_Event_Count !== 8'd1) begin
      bad++; $display("FAIL held_reset_then_short got s=%b evt=%0d exp 1/1", o_Short_Press, o_Event_Count);
    end
  endtask

  task automatic test_reset_mid_press;
    repeat (5) cyc(1'b1);
    i_Reset = 1'b1;
    cyc(1'b1);
    i_Reset = 1'b0;
    total++;
    if ({o_Short_Press, o_Long_Press, o_Double_Press, o_Held, o_Event_Count} !== 12'h000) begin
      bad++; $display("FAIL midreset_outputs got=%h exp=000",
        {o_Short_Press, o_Long_Press, o_Double_Press, o_Held, o_Event_Count});
    end
    clr();
    repeat (20) cyc(1'b1);
    total++;
    if (n_l !== 0 || held_seen !== 0 || o_Event_Count !== 8'd0) begin
      bad++; $display("FAIL midreset_no_long got l=%0d held=%0d evt=%0d exp 0/0/0",
                      n_l, held_seen, o_Event_Count);
    end
    cyc(1'b0);
  endtask

  task automatic test_wrap;
    i_Reset = 1'b1;
    cyc(1'b0);
    i_Reset = 1'b0;
    cyc(1'b0);
    for (int i = 1; i <= 257; i++) begin
      cyc(1'b1);
      repeat (4) cyc(1'b0);
      if (i == 255) begin
        total++;
        if (o_Event_Count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", o_Event_Count); end
      end
      if (i == 256) begin
        total++;
        if (o_Event_Count !== 8'd0) begin bad++; $display("FAIL wrap_256 got=%0d exp=0", o_Event_Count); end
      end
    end
    total++;
    if (o_Event_Count !== 8'd1) begin bad++; $display("FAIL wrap_257 got=%0d exp=1", o_Event_Count); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double_boundary();
    test_held_through_reset();
    test_reset_mid_press();
    test_wrap();
    total++;
    if (multi !== 0) begin bad++; $display("FAIL strobe_exclusive got=%0d exp=0", multi); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
